seg7_card_reader: RTL and testbench

- Reverse path of the card-to-seven-segment encoder: observes a time-multiplexed seven-segment bus (active-low pattern plus digit index) driving the card displays.
- Recovers the 4-bit card code shown on each digit and requires a pattern to be stable before accepting it.
- Reports every change of a digit's committed card through a valid/ready event port.
- Used as a self-check monitor and scoreboard feeder beside the display path, both on-board and in simulation.

---
 rtl/card_pkg.sv | 37 +++
 rtl/seg7_to_card.sv | 32 +++
 rtl/seg7_card_reader.sv | 155 +++++++++++++++
 tb/tb_seg7_card_reader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Card codes and their active-low seven-segment patterns (bit 6 = segment g),
// shared by the card encoder and the bus reader.
package card_pkg;

  typedef enum logic [3:0] {
    CARD_BLANK = 4'd0,
    CARD_ACE   = 4'd1,
    CARD_2     = 4'd2,
    CARD_3     = 4'd3,
    CARD_4     = 4'd4,
    CARD_5     = 4'd5,
    CARD_6     = 4'd6,
    CARD_7     = 4'd7,
    CARD_8     = 4'd8,
    CARD_9     = 4'd9,
    CARD_10    = 4'd10,
    CARD_JACK  = 4'd11,
    CARD_QUEEN = 4'd12,
    CARD_KING  = 4'd13
  } card_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ACE   = 7'b0001000;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_10    = 7'b1000000;
  localparam logic [6:0] SEG_JACK  = 7'b1100001;
  localparam logic [6:0] SEG_QUEEN = 7'b0011000;
  localparam logic [6:0] SEG_KING  = 7'b0001001;

endpackage

// File: rtl/seg7_to_card.sv
// Exact-match decode of an active-low segment pattern back to a card code.
module seg7_to_card
  import card_pkg::*;
(
  input  logic [6:0] seg_pat,
  output card_t      code,
  output logic       legal
);

  always_comb begin
    code  = CARD_BLANK;
    legal = 1'b1;
    case (seg_pat)
      SEG_BLANK: code = CARD_BLANK;
      SEG_ACE:   code = CARD_ACE;
      SEG_2:     code = CARD_2;
      SEG_3:     code = CARD_3;
      SEG_4:     code = CARD_4;
      SEG_5:     code = CARD_5;
      SEG_6:     code = CARD_6;
      SEG_7:     code = CARD_7;
      SEG_8:     code = CARD_8;
      SEG_9:     code = CARD_9;
      SEG_10:    code = CARD_10;
      SEG_JACK:  code = CARD_JACK;
      SEG_QUEEN: code = CARD_QUEEN;
      SEG_KING:  code = CARD_KING;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_card_reader.sv
// Monitors a multiplexed seven-segment bus, debounces each digit's pattern and
// reports every change of a digit's committed card through a valid/ready port.
module seg7_card_reader
  import card_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    seg_valid,
  input  logic [2:0]              digit_sel,
  input  logic [6:0]              seg_pat,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [2:0]              evt_idx,
  output logic [3:0]              evt_card,
  output logic [4*NUM_DIGITS-1:0] cards_flat,
  output logic                    err,
  output logic [2:0]              err_idx,
  input  logic                    err_clr
);

  localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  logic [6:0]       cand_pat_q [NUM_DIGITS];
  logic [6:0]       cand_pat_d [NUM_DIGITS];
  logic [CNT_W-1:0] cand_cnt_q [NUM_DIGITS];
  logic [CNT_W-1:0] cand_cnt_d [NUM_DIGITS];
  card_t            committed_q[NUM_DIGITS];
  card_t            committed_d[NUM_DIGITS];
  logic [NUM_DIGITS-1:0] pending_q, pending_d, pend_set, pend_clr, pick_onehot;
  logic [0:0]       state_q, state_d;
  logic [2:0]       evt_idx_q, evt_idx_d, err_idx_q, err_idx_d, pick_idx;
  card_t            evt_card_q, evt_card_d, pick_card, dec_code;
  logic             err_q, err_d, dec_legal, strobe_ok, commit_fire, pick_found;

  seg7_to_card u_dec (
    .seg_pat (seg_pat),
    .code    (dec_code),
    .legal   (dec_legal)
  );

  assign strobe_ok = seg_valid && (32'(digit_sel) < NUM_DIGITS);

  // Debounce per digit; a commit fires only on the strobe that reaches STABLE_CNT.
  always_comb begin
    cand_pat_d  = cand_pat_q;
    cand_cnt_d  = cand_cnt_q;
    committed_d = committed_q;
    pend_set    = '0;
    err_d       = err_q;
    err_idx_d   = err_idx_q;
    commit_fire = 1'b0;
    if (err_clr) err_d = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (strobe_ok && digit_sel == 3'(i)) begin
        if (seg_pat == cand_pat_q[i]) begin
          if (cand_cnt_q[i] != CNT_MAX) cand_cnt_d[i] = cand_cnt_q[i] + CNT_W'(1);
          commit_fire = (cand_cnt_q[i] == CNT_MAX - CNT_W'(1));
        end else begin
          cand_pat_d[i] = seg_pat;
          cand_cnt_d[i] = CNT_W'(1);
          commit_fire   = (STABLE_CNT == 1);
        end
        if (commit_fire) begin
          if (!dec_legal) begin
            err_d     = 1'b1;
            err_idx_d = digit_sel;
          end else if (dec_code != committed_q[i]) begin
            committed_d[i] = dec_code;
            pend_set[i]    = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = '0;
    pick_card   = CARD_BLANK;
    pick_onehot = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (pending_q[i] && !pick_found) begin
        pick_found     = 1'b1;
        pick_idx       = 3'(i);
        pick_card      = committed_q[i];
        pick_onehot[i] = 1'b1;
      end
    end
  end

  // Set of a pending bit wins over the clear issued when that digit is picked.
  always_comb begin
    state_d    = state_q;
    evt_idx_d  = evt_idx_q;
    evt_card_d = evt_card_q;
    pend_clr   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d    = ST_PRESENT;
          evt_idx_d  = pick_idx;
          evt_card_d = pick_card;
          pend_clr   = pick_onehot;
        end
      end
      ST_PRESENT: if (evt_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    pending_d = (pending_q & ~pend_clr) | pend_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        cand_pat_q[i]  <= '1;
        cand_cnt_q[i]  <= '0;
        committed_q[i] <= CARD_BLANK;
      end
      pending_q  <= '0;
      state_q    <= ST_IDLE;
      evt_idx_q  <= '0;
      evt_card_q <= CARD_BLANK;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      cand_pat_q  <= cand_pat_d;
      cand_cnt_q  <= cand_cnt_d;
      committed_q <= committed_d;
      pending_q   <= pending_d;
      state_q     <= state_d;
      evt_idx_q   <= evt_idx_d;
      evt_card_q  <= evt_card_d;
      err_q       <= err_d;
      err_idx_q   <= err_idx_d;
    end
  end

  always_comb begin
    cards_flat = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) cards_flat[4*i +: 4] = committed_q[i];
  end

  assign evt_valid = (state_q == ST_PRESENT);
  assign evt_idx   = evt_idx_q;
  assign evt_card  = evt_card_q;
  assign err       = err_q;
  assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_seg7_card_reader.sv
// Bench for seg7_card_reader: decode table vectors plus directed event sequences,
// with expected events queued at stimulus time and checked at each handshake.
module tb_seg7_card_reader;

  logic        clk = 1'b0;
  logic        reset, seg_valid, evt_ready, err_clr;
  logic [2:0]  digit_sel;
  logic [6:0]  seg_pat;
  logic        evt_valid, err;
  logic [2:0]  evt_idx, err_idx;
  logic [3:0]  evt_card;
  logic [23:0] cards_flat;

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] card;
  } evt_t;

  typedef struct {
    logic [6:0] pat;
    logic       legal;
    logic [3:0] code;
  } dec_vec_t;

  evt_t       exp_q[$];
  logic [3:0] exp_cards[6];
  int         n_checks = 0;
  int         n_fail   = 0;

  seg7_card_reader #(.NUM_DIGITS(6), .STABLE_CNT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .seg_valid  (seg_valid),
    .digit_sel  (digit_sel),
    .seg_pat    (seg_pat),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_idx    (evt_idx),
    .evt_card   (evt_card),
    .cards_flat (cards_flat),
    .err        (err),
    .err_idx    (err_idx),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] model_flat();
    logic [23:0] f;
    for (int i = 0; i < 6; i++) f[4*i +: 4] = exp_cards[i];
    return f;
  endfunction

  // Handshake monitor: every accepted event must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got idx %0d card %0d expected none", evt_idx, evt_card);
      end else begin
        evt_t e;
        e = exp_q.pop_front();
        chk("evt_idx", 32'(evt_idx), 32'(e.idx));
        chk("evt_card", 32'(evt_card), 32'(e.card));
      end
    end
  end

  task automatic strobes(input logic [2:0] d, input logic [6:0] p, input int n);
    seg_valid = 1'b1;
    digit_sel = d;
    seg_pat   = p;
    repeat (n) @(posedge clk);
    #1 seg_valid = 1'b0;
  endtask

  task automatic expect_commit(input logic [2:0] d, input logic [3:0] code);
    if (code != exp_cards[d]) begin
      exp_q.push_back('{idx: d, card: code});
      exp_cards[d] = code;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (k < 50 && !(exp_q.size() == 0 && !evt_valid)) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
  endtask

  dec_vec_t tbl[17];

  initial begin
    tbl[0]  = '{7'b1111111, 1'b1, 4'd0};
    tbl[1]  = '{7'b0001000, 1'b1, 4'd1};
    tbl[2]  = '{7'b0100100, 1'b1, 4'd2};
    tbl[3]  = '{7'b0110000, 1'b1, 4'd3};
    tbl[4]  = '{7'b0011001, 1'b1, 4'd4};
    tbl[5]  = '{7'b0010010, 1'b1, 4'd5};
    tbl[6]  = '{7'b0000010, 1'b1, 4'd6};
    tbl[7]  = '{7'b1111000, 1'b1, 4'd7};
    tbl[8]  = '{7'b0000000, 1'b1, 4'd8};
    tbl[9]  = '{7'b0010000, 1'b1, 4'd9};
    tbl[10] = '{7'b1000000, 1'b1, 4'd10};
    tbl[11] = '{7'b1100001, 1'b1, 4'd11};
    tbl[12] = '{7'b0011000, 1'b1, 4'd12};
    tbl[13] = '{7'b0001001, 1'b1, 4'd13};
    tbl[14] = '{7'b0101010, 1'b0, 4'd0};
    tbl[15] = '{7'b1111110, 1'b0, 4'd0};
    tbl[16] = '{7'b0000001, 1'b0, 4'd0};

    for (int i = 0; i < 6; i++) exp_cards[i] = 4'd0;
    reset = 1'b1; seg_valid = 1'b0; digit_sel = '0; seg_pat = '1;
    evt_ready = 1'b1; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_evt_idx", 32'(evt_idx), 32'd0);
    chk("rst_evt_card", 32'(evt_card), 32'd0);
    chk("rst_cards", 32'(cards_flat), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_idx", 32'(err_idx), 32'd0);

    // First commit: cards visible next cycle, event one cycle after that.
    expect_commit(3'd0, 4'd1);
    strobes(3'd0, 7'b0001000, 3);
    chk("t1_cards", 32'(cards_flat), 32'(model_flat()));
    chk("t1_no_early_evt", 32'(evt_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_evt_valid", 32'(evt_valid), 32'd1);
    chk("t1_evt_idx", 32'(evt_idx), 32'd0);
    chk("t1_evt_card", 32'(evt_card), 32'd1);
    @(posedge clk); #1;
    chk("t1_evt_dropped", 32'(evt_valid), 32'd0);
    drain();

    // Decode table on digit 0.
    for (int r = 0; r < 17; r++) begin
      if (tbl[r].legal) expect_commit(3'd0, tbl[r].code);
      strobes(3'd0, tbl[r].pat, 3);
      chk($sformatf("tbl%0d_cards", r), 32'(cards_flat), 32'(model_flat()));
      chk($sformatf("tbl%0d_err", r), 32'(err), 32'(!tbl[r].legal));
      drain();
      if (!tbl[r].legal) begin
        chk($sformatf("tbl%0d_err_idx", r), 32'(err_idx), 32'd0);
        pulse_err_clr();
        chk($sformatf("tbl%0d_err_clr", r), 32'(err), 32'd0);
      end
    end

    // Candidate restart: 2x pattern 5 then 3x pattern 8 commits only 8.
    strobes(3'd2, 7'b0010010, 2);
    strobes(3'd2, 7'b0000000, 2);
    chk("t2_no_commit", 32'(cards_flat), 32'(model_flat()));
    expect_commit(3'd2, 4'd8);
    strobes(3'd2, 7'b0000000, 1);
    chk("t2_commit8", 32'(cards_flat), 32'(model_flat()));
    drain();

    // Stalled consumer: digit 1 presented and re-committed, digit 3 collapses to latest.
    evt_ready = 1'b0;
    exp_q.push_back('{idx: 3'd1, card: 4'd13});
    exp_q.push_back('{idx: 3'd1, card: 4'd12});
    exp_q.push_back('{idx: 3'd3, card: 4'd5});
    exp_cards[1] = 4'd12;
    exp_cards[3] = 4'd5;
    strobes(3'd1, 7'b0001001, 3);
    strobes(3'd3, 7'b0100100, 3);
    chk("t3_stall_idx_a", 32'(evt_idx), 32'd1);
    chk("t3_stall_card_a", 32'(evt_card), 32'd13);
    strobes(3'd1, 7'b0011000, 3);
    strobes(3'd3, 7'b0010010, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_stall_valid", 32'(evt_valid), 32'd1);
    chk("t3_stall_idx_b", 32'(evt_idx), 32'd1);
    chk("t3_stall_card_b", 32'(evt_card), 32'd13);
    chk("t3_cards", 32'(cards_flat), 32'(model_flat()));
    evt_ready = 1'b1;
    drain();

    // Illegal pattern on digit 4, then set-wins against a simultaneous clear.
    strobes(3'd4, 7'b0101010, 3);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_err_idx", 32'(err_idx), 32'd4);
    chk("t4_cards", 32'(cards_flat), 32'(model_flat()));
    pulse_err_clr();
    chk("t4_err_clr", 32'(err), 32'd0);
    strobes(3'd4, 7'b1111110, 2);
    err_clr = 1'b1;
    strobes(3'd4, 7'b1111110, 1);
    err_clr = 1'b0;
    chk("t4_set_wins", 32'(err), 32'd1);
    pulse_err_clr();
    drain();

    // Re-committing the same card is silent; out-of-range digits are ignored.
    expect_commit(3'd5, 4'd9);
    strobes(3'd5, 7'b0010000, 3);
    drain();
    strobes(3'd5, 7'b0010000, 3);
    strobes(3'd7, 7'b0001000, 3);
    strobes(3'd6, 7'b0001001, 3);
    strobes(3'd7, 7'b0101010, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_cards", 32'(cards_flat), 32'(model_flat()));
    chk("t5_err", 32'(err), 32'd0);
    chk("t5_no_evt", 32'(evt_valid), 32'd0);
    drain();

    // Reset while an event is presented.
    strobes(3'd4, 7'b0101010, 3);
    evt_ready = 1'b0;
    expect_commit(3'd0, 4'd6);
    strobes(3'd0, 7'b0000010, 3);
    @(posedge clk); #1;
    chk("t6_pre_valid", 32'(evt_valid), 32'd1);
    chk("t6_pre_err", 32'(err), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(evt_valid), 32'd0);
    chk("t6_rst_cards", 32'(cards_flat), 32'd0);
    chk("t6_rst_err", 32'(err), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_cards[i] = 4'd0;
    @(posedge clk); #1 reset = 1'b0;
    evt_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_evt", 32'(evt_valid), 32'd0);
    expect_commit(3'd0, 4'd1);
    strobes(3'd0, 7'b0001000, 3);
    chk("t6_fresh_cards", 32'(cards_flat), 32'(model_flat()));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
